seq_divider_16x8: RTL and testbench

- Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor, one quotient bit per clock.
- Produces a 16-bit quotient and an 8-bit remainder, with a start/done handshake.
- Inverse datapath of the team's 8x8 sequential multiplier.
- Sits beside the multiplier in the arithmetic unit and shares its control style: start pulse in, done flag out, results held until the next start.

---
 rtl/seq_divider_16x8.sv | 105 ++++++++++
 tb/tb_seq_divider_16x8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16x8.sv
// Restoring divider, one quotient bit per clock; results 17 edges after start (2 for divide-by-zero).
// No backpressure: start is only taken in IDLE, ignored while an operation is in flight.
module seq_divider_16x8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_a,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done_flag,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DIVIDEND_W-1:0]   q;
  logic [DIVISOR_W-1:0]    d;
  logic [DIVISOR_W-1:0]    r;
  logic [CNT_W-1:0]        cnt;
  logic                    dz_pend;

  logic [DIVISOR_W:0]      r_sh;
  logic                    ge;
  logic [DIVISOR_W-1:0]    r_nxt;
  logic [DIVIDEND_W-1:0]   q_nxt;

  // r only needs 8 stored bits: after each step it is below d; the 9th bit exists only in r_sh.
  assign r_sh  = {r, q[DIVIDEND_W-1]};
  assign ge    = (r_sh >= {1'b0, d});
  assign r_nxt = ge ? DIVISOR_W'(r_sh - {1'b0, d}) : r_sh[DIVISOR_W-1:0];
  assign q_nxt = {q[DIVIDEND_W-2:0], ge};

  assign busy      = (state == RUN);
  assign done_flag = (state == DONE);

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dz_pend)                         state_nxt = DONE;
        else if (start && (divisor != '0))   state_nxt = RUN;
      end
      RUN:     if (cnt == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero divisor spends one IDLE cycle flagged as pending so its done lands one edge after acceptance.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      dz_pend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dz_pend) begin
            quotient    <= '1;
            remainder   <= q[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
            dz_pend     <= 1'b0;
          end else if (start) begin
            q       <= dividend;
            d       <= divisor;
            r       <= '0;
            cnt     <= '0;
            dz_pend <= (divisor == '0);
          end
        end
        RUN: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Bench for seq_divider_16x8: vector table plus hand-built sequences for ignored starts, reset and input changes.
module tb_seq_divider_16x8;

  logic        clk;
  logic        reset_a;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done_flag;
  logic        div_by_zero;

  seq_divider_16x8 dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done_flag   (done_flag),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_dz;
  } vec_t;

  typedef struct {
    int q;
    int r;
    int dz;
    int lat;
    int busy_cycles;
    int t0;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard side: every done_flag cycle pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (done_flag) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done_flag with q=%0d r=%0d, expected none", quotient, remainder);
      end else begin
        e = sb.pop_front();
        chk("quotient", int'(quotient), e.q);
        chk("remainder", int'(remainder), e.r);
        chk("div_by_zero", int'(div_by_zero), e.dz);
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_cycles", busy_cnt, e.busy_cycles);
      end
    end
  end

  // Called at a negedge; holds start for one edge and returns at the following negedge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input bit push,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e.q           = int'(eq);
      e.r           = int'(er);
      e.dz          = int'(edz);
      e.lat         = edz ? 2 : 17;
      e.busy_cycles = edz ? 0 : 16;
      e.t0          = cyc;
      busy_cnt      = 0;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_a  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    tbl[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
    tbl[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
    tbl[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
    tbl[3] = '{16'd5,     8'd9,   16'd0,     8'd5,   1'b0};
    tbl[4] = '{16'd300,   8'd0,   16'hFFFF,  8'h2C,  1'b1};
    tbl[5] = '{16'd300,   8'd3,   16'd100,   8'd0,   1'b0};
    tbl[6] = '{16'd0,     8'd13,  16'd0,     8'd0,   1'b0};
    tbl[7] = '{16'd65535, 8'd128, 16'd511,   8'd127, 1'b0};
    tbl[8] = '{16'd510,   8'd255, 16'd2,     8'd0,   1'b0};
    for (int i = 9; i < 12; i++) begin
      tbl[i].dvd    = 16'($urandom_range(0, 65535));
      tbl[i].dvs    = 8'($urandom_range(1, 255));
      tbl[i].exp_q  = tbl[i].dvd / 16'(tbl[i].dvs);
      tbl[i].exp_r  = 8'(tbl[i].dvd % 16'(tbl[i].dvs));
      tbl[i].exp_dz = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_flag), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    reset_a = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      start_op(tbl[i].dvd, tbl[i].dvs, 1'b1, tbl[i].exp_q, tbl[i].exp_r, tbl[i].exp_dz);
      wait_idle();
    end

    // Starts during RUN and DONE must be dropped, the one right after DONE taken.
    start_op(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6, 1'b0);
    repeat (7) @(negedge clk);
    start_op(16'd50, 8'd5, 1'b0, 16'd0, 8'd0, 1'b0);
    for (int i = 0; i < 30 && !done_flag; i++) @(negedge clk);
    chk("done_seen", int'(done_flag), 1);
    dividend = 16'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start_op(16'd50, 8'd5, 1'b1, 16'd10, 8'd0, 1'b0);
    wait_idle();

    // Asynchronous reset in the middle of RUN, then a clean operation.
    start_op(16'd1000, 8'd7, 1'b0, 16'd0, 8'd0, 1'b0);
    repeat (9) @(negedge clk);
    #2 reset_a = 1'b0;
    #1;
    chk("arst_quotient", int'(quotient), 0);
    chk("arst_remainder", int'(remainder), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done_flag), 0);
    chk("arst_dz", int'(div_by_zero), 0);
    @(negedge clk);
    reset_a = 1'b1;
    repeat (20) @(negedge clk);
    start_op(16'd12345, 8'd100, 1'b1, 16'd123, 8'd45, 1'b0);
    wait_idle();

    // Inputs wander during RUN; outputs hold the previous result until completion.
    start_op(16'd40000, 8'd200, 1'b1, 16'd200, 8'd0, 1'b0);
    for (int i = 0; i < 20 && busy; i++) begin
      chk("hold_quotient", int'(quotient), 123);
      chk("hold_remainder", int'(remainder), 45);
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(negedge clk);
    end
    wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
